axis_byte_packer: RTL and testbench

Byte-to-word AXI4-Stream upsizer placed directly downstream of the 8-bit host-link `axis_fifo`. It gathers consecutive bytes into `OUT_BYTES`-wide words, little-endian, and emits each word with `tkeep` lane qualifiers. Words are cut short at frame boundaries (`tlast`). Its output feeds the wide command/config decoders, which then never have to handle byte-serial framing.

---
 rtl/axis_byte_packer_if.sv | 29 ++
 rtl/axis_byte_packer.sv | 94 +++++++++
 tb/tb_axis_byte_packer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axis_byte_packer_if.sv
// Stream bundle for axis_byte_packer: 8-bit byte input side and wide word output side.
// The slave modport is the packer's view; the master modport is the surrounding logic's view.
interface axis_byte_packer_if #(
  parameter int OUT_BYTES  = 4,
  parameter int USER_WIDTH = 1
);
  logic [7:0]             s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic                   s_axis_tlast;
  logic [USER_WIDTH-1:0]  s_axis_tuser;

  logic [8*OUT_BYTES-1:0] m_axis_tdata;
  logic [OUT_BYTES-1:0]   m_axis_tkeep;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;
  logic [USER_WIDTH-1:0]  m_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/axis_byte_packer.sv
// Byte-to-word AXI4-Stream upsizer: packs bytes little-endian into OUT_BYTES-wide words,
// cutting words short at tlast and OR-ing tuser across each word.
module axis_byte_packer #(
  parameter int OUT_BYTES  = 4,
  parameter int USER_WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  axis_byte_packer_if.slave   bus,
  output logic                status_short_word
);

  localparam int IDX_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES - 1);

  logic [8*OUT_BYTES-1:0] acc_data;
  logic [USER_WIDTH-1:0]  acc_user;
  logic [IDX_W-1:0]       idx;

  logic [8*OUT_BYTES-1:0] out_data;
  logic [OUT_BYTES-1:0]   out_keep;
  logic                   out_last;
  logic [USER_WIDTH-1:0]  out_user;
  logic                   out_valid;

  logic [8*OUT_BYTES-1:0] merged_data;
  logic [OUT_BYTES-1:0]   merged_keep;
  logic                   accept;
  logic                   complete;

  assign bus.s_axis_tready = rst && (!out_valid || bus.m_axis_tready);
  assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;
  assign complete          = (idx == LAST_IDX) || bus.s_axis_tlast;

  assign bus.m_axis_tdata  = out_data;
  assign bus.m_axis_tkeep  = out_keep;
  assign bus.m_axis_tlast  = out_last;
  assign bus.m_axis_tuser  = out_user;
  assign bus.m_axis_tvalid = out_valid;

  // Word as it would leave if the current byte closes it: lanes past idx are zeroed
  // so stale accumulator bytes from an earlier, longer word never leak out.
  always_comb begin
    merged_data = acc_data;
    merged_keep = '0;
    for (int k = 0; k < OUT_BYTES; k++) begin
      if (k == int'(idx)) begin
        merged_data[8*k +: 8] = bus.s_axis_tdata;
        merged_keep[k]        = 1'b1;
      end else if (k > int'(idx)) begin
        merged_data[8*k +: 8] = 8'h00;
      end else begin
        merged_keep[k]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_data          <= '0;
      acc_user          <= '0;
      idx               <= '0;
      out_data          <= '0;
      out_keep          <= '0;
      out_last          <= 1'b0;
      out_user          <= '0;
      out_valid         <= 1'b0;
      status_short_word <= 1'b0;
    end else begin
      status_short_word <= 1'b0;
      if (accept) begin
        acc_data[8*idx +: 8] <= bus.s_axis_tdata;
        if (complete) begin
          idx               <= '0;
          acc_user          <= '0;
          out_data          <= merged_data;
          out_keep          <= merged_keep;
          out_last          <= bus.s_axis_tlast;
          out_user          <= acc_user | bus.s_axis_tuser;
          out_valid         <= 1'b1;
          status_short_word <= !(&merged_keep);
        end else begin
          idx      <= idx + IDX_W'(1);
          acc_user <= acc_user | bus.s_axis_tuser;
        end
      end
      // A load in the same cycle wins over the clear, so back-to-back words see no bubble.
      if (out_valid && bus.m_axis_tready && !(accept && complete)) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer (OUT_BYTES=4): vector table for streaming frames,
// plus hand sequences for backpressure and asynchronous reset mid-word.
module tb_axis_byte_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic status_short_word;

  axis_byte_packer_if #(.OUT_BYTES(4), .USER_WIDTH(1)) bus ();

  axis_byte_packer #(.OUT_BYTES(4), .USER_WIDTH(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .status_short_word (status_short_word)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic        user;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
    logic        exp_user;
    logic        exp_short;
  } vec_t;

  vec_t vecs[$];
  int   check_count = 0;
  int   pass_count  = 0;

  task automatic check_value(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void add_vec(input logic [7:0] d, input logic l, input logic u,
                                  input logic ev, input logic [31:0] ed, input logic [3:0] ek,
                                  input logic el, input logic eu, input logic es);
    vec_t v;
    v.data = d; v.last = l; v.user = u;
    v.exp_valid = ev; v.exp_data = ed; v.exp_keep = ek;
    v.exp_last = el; v.exp_user = eu; v.exp_short = es;
    vecs.push_back(v);
  endfunction

  task automatic drive_byte(input logic [7:0] d, input logic l, input logic u);
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tuser  = u;
    bus.s_axis_tvalid = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    drive_byte(v.data, v.last, v.user);
    check_value("s_tready_stream", 128'(bus.s_axis_tready), 128'(1'b1));
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    check_value({tag, "_valid"}, 128'(bus.m_axis_tvalid), 128'(v.exp_valid));
    check_value({tag, "_short"}, 128'(status_short_word), 128'(v.exp_short));
    if (v.exp_valid) begin
      check_value({tag, "_data"}, 128'(bus.m_axis_tdata), 128'(v.exp_data));
      check_value({tag, "_keep"}, 128'(bus.m_axis_tkeep), 128'(v.exp_keep));
      check_value({tag, "_last"}, 128'(bus.m_axis_tlast), 128'(v.exp_last));
      check_value({tag, "_user"}, 128'(bus.m_axis_tuser), 128'(v.exp_user));
    end
  endtask

  initial begin
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    bus.m_axis_tready = 1'b1;

    // Aligned frame 01..08.
    add_vec(8'h01, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h02, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h03, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h04, 0, 0, 1, 32'h04030201, 4'hF, 0, 0, 0);
    add_vec(8'h05, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h06, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h07, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h08, 1, 0, 1, 32'h08070605, 4'hF, 1, 0, 0);
    // Short tail AA..EE.
    add_vec(8'hAA, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'hBB, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'hCC, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'hDD, 0, 0, 1, 32'hDDCCBBAA, 4'hF, 0, 0, 0);
    add_vec(8'hEE, 1, 0, 1, 32'h000000EE, 4'h1, 1, 0, 1);
    // One-byte frames back-to-back.
    add_vec(8'h11, 1, 0, 1, 32'h00000011, 4'h1, 1, 0, 1);
    add_vec(8'h22, 1, 0, 1, 32'h00000022, 4'h1, 1, 0, 1);
    add_vec(8'h33, 1, 0, 1, 32'h00000033, 4'h1, 1, 0, 1);
    // tuser on byte 3 of the first word only.
    add_vec(8'h41, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h42, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h43, 0, 1, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h44, 0, 0, 1, 32'h44434241, 4'hF, 0, 1, 0);
    add_vec(8'h51, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h52, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h53, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
    add_vec(8'h54, 1, 0, 1, 32'h54535251, 4'hF, 1, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    check_value("rst_valid", 128'(bus.m_axis_tvalid), 128'(1'b0));
    check_value("rst_data",  128'(bus.m_axis_tdata),  128'(32'h0));
    check_value("rst_keep",  128'(bus.m_axis_tkeep),  128'(4'h0));
    check_value("rst_last",  128'(bus.m_axis_tlast),  128'(1'b0));
    check_value("rst_user",  128'(bus.m_axis_tuser),  128'(1'b0));
    check_value("rst_short", 128'(status_short_word), 128'(1'b0));
    check_value("rst_s_tready", 128'(bus.s_axis_tready), 128'(1'b0));
    rst = 1'b1;
    #1;
    check_value("post_rst_s_tready", 128'(bus.s_axis_tready), 128'(1'b1));
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      next_cycle();
      checkOutput(vecs[i], i);
    end
    bus.s_axis_tvalid = 1'b0;
    next_cycle();
    check_value("drain_valid", 128'(bus.m_axis_tvalid), 128'(1'b0));

    // Backpressure: word 64636261 held while the sink stalls for 5 cycles.
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_byte(8'h61 + 8'(i), (i == 3), 1'b0);
      next_cycle();
    end
    check_value("bp_loaded_valid", 128'(bus.m_axis_tvalid), 128'(1'b1));
    drive_byte(8'h71, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check_value($sformatf("bp%0d_s_tready", c), 128'(bus.s_axis_tready), 128'(1'b0));
      check_value($sformatf("bp%0d_valid", c), 128'(bus.m_axis_tvalid), 128'(1'b1));
      check_value($sformatf("bp%0d_data", c), 128'(bus.m_axis_tdata), 128'(32'h64636261));
      check_value($sformatf("bp%0d_keep", c), 128'(bus.m_axis_tkeep), 128'(4'hF));
      check_value($sformatf("bp%0d_last", c), 128'(bus.m_axis_tlast), 128'(1'b1));
      next_cycle();
    end
    bus.m_axis_tready = 1'b1;
    next_cycle();
    check_value("bp_release_valid", 128'(bus.m_axis_tvalid), 128'(1'b0));
    for (int i = 1; i < 4; i++) begin
      drive_byte(8'h71 + 8'(i), (i == 3), 1'b0);
      next_cycle();
    end
    check_value("bp_next_valid", 128'(bus.m_axis_tvalid), 128'(1'b1));
    check_value("bp_next_data",  128'(bus.m_axis_tdata),  128'(32'h74737271));
    check_value("bp_next_keep",  128'(bus.m_axis_tkeep),  128'(4'hF));
    check_value("bp_next_last",  128'(bus.m_axis_tlast),  128'(1'b1));
    bus.s_axis_tvalid = 1'b0;
    next_cycle();

    // Asynchronous reset after two bytes of a word, away from any clock edge.
    drive_byte(8'hA1, 1'b0, 1'b0);
    next_cycle();
    drive_byte(8'hA2, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    #1;
    check_value("arst_valid",    128'(bus.m_axis_tvalid), 128'(1'b0));
    check_value("arst_s_tready", 128'(bus.s_axis_tready), 128'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_byte(8'h01 + 8'(i), 1'b0, 1'b0);
      next_cycle();
    end
    check_value("arst_word_valid", 128'(bus.m_axis_tvalid), 128'(1'b1));
    check_value("arst_word_data",  128'(bus.m_axis_tdata),  128'(32'h04030201));
    check_value("arst_word_keep",  128'(bus.m_axis_tkeep),  128'(4'hF));
    check_value("arst_word_last",  128'(bus.m_axis_tlast),  128'(1'b0));
    bus.s_axis_tvalid = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
